// File: rtl/rob_issue_queue_pkg.sv
// Shared widths for the ROB-to-issue path and the issue queue sizing.
package rob_issue_queue_pkg;

    localparam int ROB_ADDR_WIDTH = 6;
    localparam int OPGEN_WIDTH    = 6;
    localparam int DATA_BUS_WIDTH = 32;

    localparam int ISSUE_QUEUE_DEPTH = 4;

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int ISSUE_QUEUE_CNT_WIDTH = cnt_width(ISSUE_QUEUE_DEPTH);

endpackage

// File: rtl/rob_issue_queue_if.sv
// Enqueue, CDB and issue signals between the ROB/II register, the CDB and the EX stage.
interface rob_issue_queue_if
    import rob_issue_queue_pkg::*;
#(
    parameter int DEPTH          = ISSUE_QUEUE_DEPTH,
    parameter int ROB_ADDR_WIDTH = rob_issue_queue_pkg::ROB_ADDR_WIDTH,
    parameter int OPGEN_WIDTH    = rob_issue_queue_pkg::OPGEN_WIDTH,
    parameter int DATA_WIDTH     = DATA_BUS_WIDTH
);
    localparam int CNT_W = cnt_width(DEPTH);

    logic                      can_issue_in;
    logic                      in_ready;
    logic [ROB_ADDR_WIDTH-1:0] rob_addr_in;
    logic [OPGEN_WIDTH-1:0]    opgen_in;
    logic                      operand_is_ref_1_in;
    logic                      operand_is_ref_2_in;
    logic [DATA_WIDTH-1:0]     operand_data_1_in;
    logic [DATA_WIDTH-1:0]     operand_data_2_in;
    logic [DATA_WIDTH-1:0]     pc_in;

    logic                      cdb_valid;
    logic [ROB_ADDR_WIDTH-1:0] cdb_rob_addr;
    logic [DATA_WIDTH-1:0]     cdb_data;

    logic                      issue_valid;
    logic                      issue_ready;
    logic [ROB_ADDR_WIDTH-1:0] issue_rob_addr;
    logic [OPGEN_WIDTH-1:0]    issue_opgen;
    logic [DATA_WIDTH-1:0]     issue_pc;
    logic [DATA_WIDTH-1:0]     issue_operand_1;
    logic [DATA_WIDTH-1:0]     issue_operand_2;

    logic [CNT_W-1:0]          count;

    modport master (
        output can_issue_in, rob_addr_in, opgen_in, operand_is_ref_1_in,
               operand_is_ref_2_in, operand_data_1_in, operand_data_2_in, pc_in,
               cdb_valid, cdb_rob_addr, cdb_data, issue_ready,
        input  in_ready, issue_valid, issue_rob_addr, issue_opgen, issue_pc,
               issue_operand_1, issue_operand_2, count
    );

    modport slave (
        input  can_issue_in, rob_addr_in, opgen_in, operand_is_ref_1_in,
               operand_is_ref_2_in, operand_data_1_in, operand_data_2_in, pc_in,
               cdb_valid, cdb_rob_addr, cdb_data, issue_ready,
        output in_ready, issue_valid, issue_rob_addr, issue_opgen, issue_pc,
               issue_operand_1, issue_operand_2, count
    );

endinterface

// File: rtl/rob_issue_select.sv
// Priority encoder: index of the lowest (oldest) set bit of the ready mask.
module rob_issue_select #(
    parameter int DEPTH = 4,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] ready,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ready[i]) begin
                idx   = IDX_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rob_issue_queue.sv
// Compacting age-ordered issue queue with CDB wakeup and oldest-ready issue to EX.
module rob_issue_queue
    import rob_issue_queue_pkg::*;
#(
    parameter int DEPTH          = ISSUE_QUEUE_DEPTH,
    parameter int ROB_ADDR_WIDTH = rob_issue_queue_pkg::ROB_ADDR_WIDTH,
    parameter int OPGEN_WIDTH    = rob_issue_queue_pkg::OPGEN_WIDTH,
    parameter int DATA_WIDTH     = DATA_BUS_WIDTH
) (
    input logic              clk,
    input logic              rst,
    input logic              flush,
    rob_issue_queue_if.slave q
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = cnt_width(DEPTH);

    logic [DEPTH-1:0]          vld, ref1, ref2;
    logic [ROB_ADDR_WIDTH-1:0] rob  [DEPTH];
    logic [OPGEN_WIDTH-1:0]    opg  [DEPTH];
    logic [DATA_WIDTH-1:0]     pc   [DEPTH];
    logic [DATA_WIDTH-1:0]     d1   [DEPTH];
    logic [DATA_WIDTH-1:0]     d2   [DEPTH];
    logic [CNT_W-1:0]          cnt;

    logic [DEPTH-1:0]          vld_n, ref1_n, ref2_n;
    logic [ROB_ADDR_WIDTH-1:0] rob_n [DEPTH];
    logic [OPGEN_WIDTH-1:0]    opg_n [DEPTH];
    logic [DATA_WIDTH-1:0]     pc_n  [DEPTH];
    logic [DATA_WIDTH-1:0]     d1_n  [DEPTH];
    logic [DATA_WIDTH-1:0]     d2_n  [DEPTH];

    logic [DEPTH-1:0] rdy_mask;
    logic [IDX_W-1:0] sel;
    logic             found;
    logic             enq, deq;
    logic             in_ref1, in_ref2;
    logic [CNT_W-1:0] wptr;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            rdy_mask[i] = vld[i] & ~ref1[i] & ~ref2[i];
        end
    end

    rob_issue_select #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_select (
        .ready (rdy_mask),
        .idx   (sel),
        .found (found)
    );

    assign q.in_ready = (cnt != CNT_W'(DEPTH));
    assign enq        = q.can_issue_in & q.in_ready;
    assign deq        = found & q.issue_ready;
    assign wptr       = cnt - CNT_W'(deq);

    // Incoming operands see the same CDB broadcast as the stored entries.
    assign in_ref1 = q.operand_is_ref_1_in &&
                     !(q.cdb_valid && q.operand_data_1_in[ROB_ADDR_WIDTH-1:0] == q.cdb_rob_addr);
    assign in_ref2 = q.operand_is_ref_2_in &&
                     !(q.cdb_valid && q.operand_data_2_in[ROB_ADDR_WIDTH-1:0] == q.cdb_rob_addr);

    assign q.issue_valid     = found;
    assign q.issue_rob_addr  = found ? rob[sel] : '0;
    assign q.issue_opgen     = found ? opg[sel] : '0;
    assign q.issue_pc        = found ? pc[sel]  : '0;
    assign q.issue_operand_1 = found ? d1[sel]  : '0;
    assign q.issue_operand_2 = found ? d2[sel]  : '0;
    assign q.count           = cnt;

    always_comb begin
        vld_n  = vld;
        ref1_n = ref1;
        ref2_n = ref2;
        rob_n  = rob;
        opg_n  = opg;
        pc_n   = pc;
        d1_n   = d1;
        d2_n   = d2;

        for (int i = 0; i < DEPTH; i++) begin
            if (q.cdb_valid && vld[i] && ref1[i] && d1[i][ROB_ADDR_WIDTH-1:0] == q.cdb_rob_addr) begin
                ref1_n[i] = 1'b0;
                d1_n[i]   = q.cdb_data;
            end
            if (q.cdb_valid && vld[i] && ref2[i] && d2[i][ROB_ADDR_WIDTH-1:0] == q.cdb_rob_addr) begin
                ref2_n[i] = 1'b0;
                d2_n[i]   = q.cdb_data;
            end
        end

        // Close the gap left by the issued entry; woken values shift with it.
        if (deq) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                if (i >= int'(sel)) begin
                    vld_n[i]  = vld_n[i+1];
                    ref1_n[i] = ref1_n[i+1];
                    ref2_n[i] = ref2_n[i+1];
                    rob_n[i]  = rob_n[i+1];
                    opg_n[i]  = opg_n[i+1];
                    pc_n[i]   = pc_n[i+1];
                    d1_n[i]   = d1_n[i+1];
                    d2_n[i]   = d2_n[i+1];
                end
            end
            vld_n[DEPTH-1] = 1'b0;
        end

        if (enq) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i == int'(wptr)) begin
                    vld_n[i]  = 1'b1;
                    ref1_n[i] = in_ref1;
                    ref2_n[i] = in_ref2;
                    rob_n[i]  = q.rob_addr_in;
                    opg_n[i]  = q.opgen_in;
                    pc_n[i]   = q.pc_in;
                    d1_n[i]   = in_ref1 ? q.operand_data_1_in : (q.operand_is_ref_1_in ? q.cdb_data : q.operand_data_1_in);
                    d2_n[i]   = in_ref2 ? q.operand_data_2_in : (q.operand_is_ref_2_in ? q.cdb_data : q.operand_data_2_in);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            vld <= '0;
            cnt <= '0;
        end else begin
            vld <= vld_n;
            cnt <= cnt + CNT_W'(enq) - CNT_W'(deq);
        end
    end

    // Payload is qualified by vld, so it needs no reset.
    always_ff @(posedge clk) begin
        ref1 <= ref1_n;
        ref2 <= ref2_n;
        rob  <= rob_n;
        opg  <= opg_n;
        pc   <= pc_n;
        d1   <= d1_n;
        d2   <= d2_n;
    end

endmodule

// File: tb/tb_rob_issue_queue.sv
// Directed bench for rob_issue_queue: reset/flush, fill, wakeup, same-cycle capture, out-of-order and simultaneous enq/deq.
module tb_rob_issue_queue;
    import rob_issue_queue_pkg::*;

    localparam int D  = 4;
    localparam int RW = ROB_ADDR_WIDTH;
    localparam int OW = OPGEN_WIDTH;
    localparam int DW = DATA_BUS_WIDTH;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    rob_issue_queue_if #(.DEPTH(D), .ROB_ADDR_WIDTH(RW), .OPGEN_WIDTH(OW), .DATA_WIDTH(DW)) q ();

    rob_issue_queue #(.DEPTH(D), .ROB_ADDR_WIDTH(RW), .OPGEN_WIDTH(OW), .DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .q     (q)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        q.can_issue_in = 1'b0;
        q.cdb_valid    = 1'b0;
    endtask

    task automatic put(input int rob, input logic r1, input logic [DW-1:0] v1,
                       input logic r2, input logic [DW-1:0] v2);
        q.can_issue_in        = 1'b1;
        q.rob_addr_in         = RW'(rob);
        q.opgen_in            = OW'(rob + 3);
        q.pc_in               = DW'(32'h100 * rob);
        q.operand_is_ref_1_in = r1;
        q.operand_data_1_in   = v1;
        q.operand_is_ref_2_in = r2;
        q.operand_data_2_in   = v2;
    endtask

    task automatic cdb(input int tag, input logic [DW-1:0] v);
        q.cdb_valid    = 1'b1;
        q.cdb_rob_addr = RW'(tag);
        q.cdb_data     = v;
    endtask

    initial begin
        rst = 1'b0;
        flush = 1'b0;
        q.issue_ready = 1'b0;
        q.rob_addr_in = '0;
        q.opgen_in = '0;
        q.pc_in = '0;
        q.operand_is_ref_1_in = 1'b0;
        q.operand_is_ref_2_in = 1'b0;
        q.operand_data_1_in = '0;
        q.operand_data_2_in = '0;
        q.cdb_rob_addr = '0;
        q.cdb_data = '0;
        idle();
        tick();
        chk("reset_count", 64'(q.count), 0);
        chk("reset_in_ready", 64'(q.in_ready), 1);
        chk("reset_issue_valid", 64'(q.issue_valid), 0);
        chk("reset_issue_rob", 64'(q.issue_rob_addr), 0);
        chk("reset_issue_op1", 64'(q.issue_operand_1), 0);
        rst = 1'b1;

        // three entries then a mid-operation reset
        for (int k = 1; k <= 3; k++) begin
            put(k, 1'b0, DW'(k), 1'b0, DW'(0));
            tick();
        end
        idle();
        chk("pre_rst_count", 64'(q.count), 3);
        chk("pre_rst_head", 64'(q.issue_rob_addr), 1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("rst_count", 64'(q.count), 0);
        chk("rst_issue_valid", 64'(q.issue_valid), 0);
        chk("rst_in_ready", 64'(q.in_ready), 1);
        chk("rst_issue_pc", 64'(q.issue_pc), 0);

        // flush overrides a simultaneous enqueue
        for (int k = 1; k <= 2; k++) begin
            put(k, 1'b0, DW'(k), 1'b0, DW'(0));
            tick();
        end
        chk("pre_flush_count", 64'(q.count), 2);
        put(7, 1'b0, DW'(7), 1'b0, DW'(0));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle();
        chk("flush_count", 64'(q.count), 0);
        chk("flush_issue_valid", 64'(q.issue_valid), 0);

        // fill with back-pressure, then drain in order
        for (int k = 1; k <= 4; k++) begin
            put(k, 1'b0, DW'(32'h10 + k), 1'b0, DW'(32'h20 + k));
            tick();
        end
        chk("full_count", 64'(q.count), 4);
        chk("full_in_ready", 64'(q.in_ready), 0);
        put(5, 1'b0, DW'(5), 1'b0, DW'(5));
        tick();
        idle();
        chk("reject_count", 64'(q.count), 4);
        chk("full_head_opgen", 64'(q.issue_opgen), 4);
        q.issue_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("drain_rob_%0d", k), 64'(q.issue_rob_addr), 64'(k));
            chk($sformatf("drain_op1_%0d", k), 64'(q.issue_operand_1), 64'(32'h10 + k));
            chk($sformatf("drain_pc_%0d", k), 64'(q.issue_pc), 64'(32'h100 * k));
            tick();
        end
        chk("drained_count", 64'(q.count), 0);
        chk("drained_valid", 64'(q.issue_valid), 0);

        // wakeup from CDB
        put(5, 1'b1, DW'(3), 1'b0, DW'(32'h22));
        tick();
        idle();
        chk("wait_count", 64'(q.count), 1);
        chk("wait_valid", 64'(q.issue_valid), 0);
        cdb(3, DW'(32'hDEADBEEF));
        tick();
        idle();
        chk("wake_valid", 64'(q.issue_valid), 1);
        chk("wake_rob", 64'(q.issue_rob_addr), 5);
        chk("wake_op1", 64'(q.issue_operand_1), 64'(32'hDEADBEEF));
        chk("wake_op2", 64'(q.issue_operand_2), 64'(32'h22));
        tick();
        chk("wake_done_count", 64'(q.count), 0);

        // same-cycle capture on enqueue
        put(6, 1'b0, DW'(32'h11), 1'b1, DW'(7));
        cdb(7, DW'(32'h55));
        tick();
        idle();
        chk("same_valid", 64'(q.issue_valid), 1);
        chk("same_rob", 64'(q.issue_rob_addr), 6);
        chk("same_op2", 64'(q.issue_operand_2), 64'(32'h55));
        tick();
        chk("same_done_count", 64'(q.count), 0);

        // younger ready entry issues ahead of an older waiting one
        q.issue_ready = 1'b0;
        put(8, 1'b1, DW'(2), 1'b0, DW'(32'h8));
        tick();
        put(9, 1'b0, DW'(32'h9), 1'b0, DW'(32'h9));
        tick();
        idle();
        chk("ooo_count", 64'(q.count), 2);
        chk("ooo_first", 64'(q.issue_rob_addr), 9);
        q.issue_ready = 1'b1;
        tick();
        chk("ooo_after_count", 64'(q.count), 1);
        chk("ooo_after_valid", 64'(q.issue_valid), 0);
        cdb(2, DW'(32'hABC));
        tick();
        idle();
        chk("ooo_second", 64'(q.issue_rob_addr), 8);
        chk("ooo_second_op1", 64'(q.issue_operand_1), 64'(32'hABC));
        tick();
        chk("ooo_done_count", 64'(q.count), 0);

        // simultaneous enqueue and dequeue at count=3
        q.issue_ready = 1'b0;
        for (int k = 10; k <= 12; k++) begin
            put(k, 1'b0, DW'(k), 1'b0, DW'(0));
            tick();
        end
        idle();
        chk("sim_pre_count", 64'(q.count), 3);
        chk("sim_pre_head", 64'(q.issue_rob_addr), 10);
        q.issue_ready = 1'b1;
        put(13, 1'b0, DW'(13), 1'b0, DW'(0));
        tick();
        idle();
        q.issue_ready = 1'b0;
        chk("sim_count", 64'(q.count), 3);
        chk("sim_head", 64'(q.issue_rob_addr), 11);
        chk("sim_idx2", 64'(dut.rob[2]), 13);
        q.issue_ready = 1'b1;
        for (int k = 11; k <= 13; k++) begin
            chk($sformatf("sim_order_%0d", k), 64'(q.issue_rob_addr), 64'(k));
            tick();
        end
        chk("sim_done_count", 64'(q.count), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
